// File: rtl/tb_mem_dma_copier_pkg.sv
// Shared types for the tb_memory access bus and the DMA block copier.
package tb_mem_dma_copier_pkg;

  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned REM_MAX_W = 32;

  // Access size encoding understood by tb_memory.
  typedef enum logic [1:0] {
    cpu_data_acc_sz_8  = 2'd0,
    cpu_data_acc_sz_16 = 2'd1,
    cpu_data_acc_sz_32 = 2'd2
  } cpu_data_acc_sz_t;

  // Request bundle driven into tb_memory by whichever master owns it.
  typedef struct packed {
    logic [ADDR_W-1:0] read_addr_in;
    cpu_data_acc_sz_t  read_data_acc_sz;
    logic [ADDR_W-1:0] write_addr_in;
    logic [DATA_W-1:0] write_data_in;
    cpu_data_acc_sz_t  write_data_acc_sz;
    logic              write_data_we;
  } tb_mem_inputs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } tb_dma_state_t;

  // Halfword only when both pointers are even and at least two bytes remain.
  function automatic cpu_data_acc_sz_t tb_dma_chunk(input logic src0,
                                                    input logic dst0,
                                                    input logic [REM_MAX_W-1:0] remaining);
    if (!src0 && !dst0 && (remaining >= REM_MAX_W'(2))) begin
      return cpu_data_acc_sz_16;
    end
    return cpu_data_acc_sz_8;
  endfunction

endpackage

// File: rtl/tb_mem_dma_copier.sv
// Byte-block copier that masters tb_memory: read chunk, write chunk, repeat.
module tb_mem_dma_copier
  import tb_mem_dma_copier_pkg::*;
#(
  parameter int unsigned len_width = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [ADDR_W-1:0]    src_addr,
  input  logic [ADDR_W-1:0]    dst_addr,
  input  logic [len_width-1:0] len,
  input  logic [DATA_W-1:0]    read_data_in,
  output tb_mem_inputs         mem_out,
  output logic                 busy,
  output logic                 done,
  output logic [len_width-1:0] bytes_done
);

  tb_dma_state_t          state_q, state_d;
  logic [ADDR_W-1:0]      src_q, src_d;
  logic [ADDR_W-1:0]      dst_q, dst_d;
  logic [len_width-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]      hold_q, hold_d;
  cpu_data_acc_sz_t       chunk_q, chunk_d;
  logic [len_width-1:0]   bytes_done_d;
  logic                   busy_d;
  logic                   done_d;
  tb_mem_inputs           mem_out_d;
  logic [1:0]             step;

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      rem_q      <= '0;
      hold_q     <= '0;
      chunk_q    <= cpu_data_acc_sz_8;
      bytes_done <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      mem_out    <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      rem_q      <= rem_d;
      hold_q     <= hold_d;
      chunk_q    <= chunk_d;
      bytes_done <= bytes_done_d;
      busy       <= busy_d;
      done       <= done_d;
      mem_out    <= mem_out_d;
    end
  end

  // Next state, datapath update, and the bus request for the coming cycle.
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    rem_d        = rem_q;
    hold_d       = hold_q;
    chunk_d      = chunk_q;
    bytes_done_d = bytes_done;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    mem_out_d    = '0;
    step         = (chunk_q == cpu_data_acc_sz_16) ? 2'd2 : 2'd1;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          src_d        = src_addr;
          dst_d        = dst_addr;
          rem_d        = len;
          bytes_done_d = '0;
          chunk_d      = tb_dma_chunk(src_addr[0], dst_addr[0], REM_MAX_W'(len));
          state_d      = (len == '0) ? DONE : READ;
        end
      end
      READ: begin
        hold_d  = read_data_in;
        state_d = abort ? IDLE : WRITE;
      end
      WRITE: begin
        // The write issued this cycle lands at this edge even when aborting.
        src_d        = src_q + ADDR_W'(step);
        dst_d        = dst_q + ADDR_W'(step);
        rem_d        = rem_q - len_width'(step);
        bytes_done_d = bytes_done + len_width'(step);
        chunk_d      = tb_dma_chunk(src_d[0], dst_d[0], REM_MAX_W'(rem_d));
        if (abort) begin
          state_d = IDLE;
        end else if (rem_d == '0) begin
          state_d = DONE;
        end else begin
          state_d = READ;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == READ) || (state_d == WRITE);
    done_d = (state_d == DONE);

    if (state_d == READ) begin
      mem_out_d.read_addr_in     = src_d;
      mem_out_d.read_data_acc_sz = chunk_d;
    end
    if (state_d == WRITE) begin
      mem_out_d.write_addr_in     = dst_d;
      mem_out_d.write_data_in     = (chunk_d == cpu_data_acc_sz_16) ? hold_d
                                                                    : {8'h00, hold_d[7:0]};
      mem_out_d.write_data_acc_sz = chunk_d;
      mem_out_d.write_data_we     = 1'b1;
    end
  end

endmodule

// File: tb/tb_tb_mem_dma_copier.sv
// Scoreboarded bench: behavioural tb_memory plus directed copy scenarios.
module tb_tb_mem_dma_copier;
  import tb_mem_dma_copier_pkg::*;

  localparam int unsigned LW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [15:0]   src_addr = '0;
  logic [15:0]   dst_addr = '0;
  logic [LW-1:0] len = '0;
  logic [15:0]   read_data_in;
  tb_mem_inputs  mem_out;
  logic          busy;
  logic          done;
  logic [LW-1:0] bytes_done;

  tb_mem_dma_copier #(.len_width(LW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .src_addr     (src_addr),
    .dst_addr     (dst_addr),
    .len          (len),
    .read_data_in (read_data_in),
    .mem_out      (mem_out),
    .busy         (busy),
    .done         (done),
    .bytes_done   (bytes_done)
  );

  always #5 clk = ~clk;

  // Little-endian byte memory, asynchronous read, write on posedge.
  logic [7:0] mem [0:65535];
  logic [15:0] rd_a1;
  logic [15:0] wr_a1;
  assign rd_a1 = mem_out.read_addr_in + 16'd1;
  assign wr_a1 = mem_out.write_addr_in + 16'd1;
  assign read_data_in = (mem_out.read_data_acc_sz == cpu_data_acc_sz_16)
                        ? {mem[rd_a1], mem[mem_out.read_addr_in]}
                        : {8'h00, mem[mem_out.read_addr_in]};

  always @(posedge clk) begin
    if (mem_out.write_data_we) begin
      mem[mem_out.write_addr_in] = mem_out.write_data_in[7:0];
      if (mem_out.write_data_acc_sz == cpu_data_acc_sz_16)
        mem[wr_a1] = mem_out.write_data_in[15:8];
    end
  end

  typedef struct {
    bit          is_done;
    logic [15:0] addr;
    logic [15:0] data;
    bit          is16;
    logic [15:0] bytes;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void push_wr(logic [15:0] a, logic [15:0] d, bit w16);
    exp_t e;
    e.is_done = 1'b0; e.addr = a; e.data = d; e.is16 = w16; e.bytes = '0;
    sb.push_back(e);
  endfunction

  function automatic void push_done(logic [15:0] b);
    exp_t e;
    e.is_done = 1'b1; e.addr = '0; e.data = '0; e.is16 = 1'b0; e.bytes = b;
    sb.push_back(e);
  endfunction

  // Monitor: every write strobe and done pulse must match the next expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset) begin
      if (mem_out.write_data_we) begin
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected none",
                   mem_out.write_addr_in, mem_out.write_data_in);
        end else begin
          e = sb.pop_front();
          check("wr_is_write", 32'(e.is_done), 32'd0);
          check("wr_addr", 32'(mem_out.write_addr_in), 32'(e.addr));
          check("wr_size", 32'(mem_out.write_data_acc_sz == cpu_data_acc_sz_16), 32'(e.is16));
          check("wr_data", e.is16 ? 32'(mem_out.write_data_in)
                                  : 32'(mem_out.write_data_in[7:0]), 32'(e.data));
        end
      end
      if (done) begin
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_done: bytes_done 0x%0h, expected no done", bytes_done);
        end else begin
          e = sb.pop_front();
          check("done_is_done", 32'(e.is_done), 32'd1);
          check("done_bytes", 32'(bytes_done), 32'(e.bytes));
        end
      end
    end
  end

  task automatic go(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
    @(negedge clk);
    src_addr = s; dst_addr = d; len = l; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts edges after the start edge until done is seen high.
  task automatic wait_done(input int exp_edges, input string name);
    int cyc = 0;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL %s: done never rose within 40 cycles, expected after %0d edges",
               name, exp_edges);
    end else begin
      check(name, 32'(cyc), 32'(exp_edges));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0100] = 8'h11; mem[16'h0101] = 8'h22;
    mem[16'h0102] = 8'h33; mem[16'h0103] = 8'h44;
    mem[16'h0303] = 8'hA5;
    mem[16'h0400] = 8'hDE; mem[16'h0401] = 8'hAD;
    mem[16'h0402] = 8'hBE; mem[16'h0403] = 8'hEF;
    for (int i = 0; i < 8; i++) mem[16'h0500 + i] = 8'(i + 1);
    mem[16'h0604] = 8'hCC;
    mem[16'h0700] = 8'h5A;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_out", 32'(mem_out == '0), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bytes_done", 32'(bytes_done), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Zero-length copy.
    push_done(16'd0);
    go(16'h0010, 16'h0020, 16'd0);
    wait_done(0, "len0_latency");

    // Aligned 4-byte copy.
    push_wr(16'h0200, 16'h2211, 1'b1);
    push_wr(16'h0202, 16'h4433, 1'b1);
    push_done(16'd4);
    go(16'h0100, 16'h0200, 16'd4);
    wait_done(4, "aligned4_latency");
    check("aligned4_mem", {mem[16'h0203], mem[16'h0202], mem[16'h0201], mem[16'h0200]},
          32'h4433_2211);

    // Odd source: three byte transfers.
    push_wr(16'h0300, 16'h0022, 1'b0);
    push_wr(16'h0301, 16'h0033, 1'b0);
    push_wr(16'h0302, 16'h0044, 1'b0);
    push_done(16'd3);
    go(16'h0101, 16'h0300, 16'd3);
    wait_done(6, "odd3_latency");
    check("odd3_mem", {mem[16'h0303], mem[16'h0302], mem[16'h0301], mem[16'h0300]},
          32'hA544_3322);

    // Even source, odd length: halfword then byte.
    push_wr(16'h0300, 16'h2211, 1'b1);
    push_wr(16'h0302, 16'h0033, 1'b0);
    push_done(16'd3);
    go(16'h0100, 16'h0300, 16'd3);
    wait_done(4, "mixed3_latency");
    check("mixed3_mem", {mem[16'h0303], mem[16'h0302], mem[16'h0301], mem[16'h0300]},
          32'hA533_2211);

    // Destination wraps past 0xFFFF.
    push_wr(16'hFFFE, 16'hADDE, 1'b1);
    push_wr(16'h0000, 16'hEFBE, 1'b1);
    push_done(16'd4);
    go(16'h0400, 16'hFFFE, 16'd4);
    wait_done(4, "wrap_latency");
    check("wrap_mem", {mem[16'h0001], mem[16'h0000], mem[16'hFFFF], mem[16'hFFFE]},
          32'hEFBE_ADDE);

    // Abort in the second WRITE cycle, start held high throughout the copy.
    push_wr(16'h0600, 16'h0201, 1'b1);
    push_wr(16'h0602, 16'h0403, 1'b1);
    @(negedge clk);
    src_addr = 16'h0500; dst_addr = 16'h0600; len = 16'd8; start = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("abort_busy_before", 32'(busy), 32'd1);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0; start = 1'b0;
    check("abort_busy_after", 32'(busy), 32'd0);
    check("abort_bytes_done", 32'(bytes_done), 32'd4);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("abort_no_done", 32'(done | busy), 32'd0);
    end
    check("abort_mem", {mem[16'h0603], mem[16'h0602], mem[16'h0601], mem[16'h0600]},
          32'h0403_0201);
    check("abort_mem_untouched", 32'(mem[16'h0604]), 32'hCC);

    // Reset asserted while a write is pending.
    push_wr(16'h0700, 16'h0201, 1'b1);
    go(16'h0500, 16'h0700, 16'd8);
    @(posedge clk); #1;
    check("pre_reset_we", 32'(mem_out.write_data_we), 32'd1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("reset_we", 32'(mem_out.write_data_we), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_bytes_done", 32'(bytes_done), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check("reset_mem_untouched", 32'(mem[16'h0700]), 32'h5A);

    // Back-to-back: start held through DONE, second copy begins from IDLE.
    push_wr(16'h0800, 16'h2211, 1'b1);
    push_done(16'd2);
    push_wr(16'h0802, 16'h4433, 1'b1);
    push_done(16'd2);
    @(negedge clk);
    src_addr = 16'h0100; dst_addr = 16'h0800; len = 16'd2; start = 1'b1;
    @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check("b2b_done_a", 32'(done), 32'd1);
    src_addr = 16'h0102; dst_addr = 16'h0802;
    @(posedge clk); #1;
    check("b2b_idle_gap", 32'(done | busy), 32'd0);
    @(posedge clk); #1;
    check("b2b_busy_b", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done(2, "b2b_latency_b");
    check("b2b_mem", {mem[16'h0803], mem[16'h0802], mem[16'h0801], mem[16'h0800]},
          32'h4433_2211);

    repeat (2) @(posedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
